// File: rtl/surf_link_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | surf_link_pkg : shared state encoding and flag decode for SURF links  |
// | Revision      : 1.0                                                   |
// +-----------------------------------------------------------------------+
package surf_link_pkg;

  typedef enum logic [2:0] {
    ST_BOOT       = 3'd0,
    ST_IDLE       = 3'd1,
    ST_TRAIN_IN   = 3'd2,
    ST_TRAIN_OUT  = 3'd3,
    ST_LIVE       = 3'd4,
    ST_MISALIGNED = 3'd5
  } surf_link_state_t;

  typedef struct packed {
    logic trainin_req;
    logic trainout_rdy;
    logic live;
    logic misaligned;
  } surf_link_flags_t;

  function automatic surf_link_flags_t surf_link_flags(input surf_link_state_t state);
    surf_link_flags_t f;
    f.trainin_req  = (state == ST_TRAIN_IN) || (state == ST_TRAIN_OUT);
    f.trainout_rdy = (state == ST_TRAIN_OUT);
    f.live         = (state == ST_LIVE);
    f.misaligned   = (state == ST_MISALIGNED);
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/surf_link_chan.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | surf_link_chan : one SURF link FSM with run and loss counters         |
// | Revision       : 1.0                                                  |
// +-----------------------------------------------------------------------+
module surf_link_chan
  import surf_link_pkg::*;
#(
  parameter int                    COUT_WIDTH     = 4,
  parameter int                    DOUT_WIDTH     = 8,
  parameter logic [DOUT_WIDTH-1:0] DOUT_TRAIN     = '0,
  parameter int                    LOSS_CYCLES    = 16,
  parameter int                    LOSS_CNT_WIDTH = 8
) (
  input  logic                      sys_clk_i,
  input  logic                      sys_rst_i,
  input  logic                      enable_i,
  input  logic [COUT_WIDTH-1:0]     cout_i,
  input  logic [DOUT_WIDTH-1:0]     dout_i,
  input  logic                      train_complete_i,
  input  logic                      misalign_clr_i,
  output logic                      trainin_req_o,
  output logic                      trainout_rdy_o,
  output logic                      surf_live_o,
  output logic                      surf_misaligned_o,
  output logic [2:0]                state_o,
  output logic [LOSS_CNT_WIDTH-1:0] loss_count_o,
  output logic                      live_change_o
);

  localparam int         RUN_W     = 8;
  localparam logic [7:0] LOSS_LAST = 8'(LOSS_CYCLES - 1);

  surf_link_state_t          state_q, state_d;
  logic [RUN_W-1:0]          run_q, run_d;
  logic [LOSS_CNT_WIDTH-1:0] loss_cnt_q, loss_cnt_d;
  logic                      live_prev_q, live_prev_d;
  logic                      live_change_q, live_change_d;

  logic             cout_ones;
  logic             dout_zero;
  logic             loss;
  logic             link_up;
  surf_link_flags_t flags;

  always_comb begin
    cout_ones = &cout_i;
    dout_zero = (dout_i == '0);
    loss      = cout_ones && (run_q == LOSS_LAST);
    link_up   = (state_q == ST_TRAIN_IN) || (state_q == ST_TRAIN_OUT) ||
                (state_q == ST_LIVE)     || (state_q == ST_MISALIGNED);

    state_d    = state_q;
    run_d      = run_q;
    loss_cnt_d = loss_cnt_q;

    if (!enable_i) begin
      state_d = ST_BOOT;
    end else begin
      case (state_q)
        ST_BOOT:       if (loss) state_d = ST_IDLE;
        ST_IDLE:       if (dout_zero) state_d = ST_TRAIN_IN;
        ST_TRAIN_IN: begin
          if (loss)            state_d = ST_IDLE;
          else if (!cout_ones) state_d = ST_TRAIN_OUT;
        end
        ST_TRAIN_OUT: begin
          if (loss) begin
            state_d = ST_IDLE;
          end else if (train_complete_i) begin
            if (dout_zero)                 state_d = ST_LIVE;
            else if (dout_i != DOUT_TRAIN) state_d = ST_MISALIGNED;
          end
        end
        ST_LIVE:       if (loss) state_d = ST_IDLE;
        ST_MISALIGNED: begin
          if (loss)                state_d = ST_IDLE;
          else if (misalign_clr_i) state_d = ST_IDLE;
        end
        default:       state_d = ST_BOOT;
      endcase

      if (loss && link_up && (loss_cnt_q != '1)) begin
        loss_cnt_d = loss_cnt_q + LOSS_CNT_WIDTH'(1);
      end

      // The all-ones run restarts on any break in COUT or any state change.
      if (!cout_ones || (state_d != state_q)) run_d = '0;
      else                                    run_d = run_q + RUN_W'(1);
    end

    live_prev_d   = (state_q == ST_LIVE);
    live_change_d = (state_q == ST_LIVE) ^ live_prev_q;
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q       <= ST_BOOT;
      run_q         <= '0;
      loss_cnt_q    <= '0;
      live_prev_q   <= 1'b0;
      live_change_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      loss_cnt_q    <= loss_cnt_d;
      live_prev_q   <= live_prev_d;
      live_change_q <= live_change_d;
    end
  end

  always_comb begin
    flags             = surf_link_flags(state_q);
    trainin_req_o     = flags.trainin_req;
    trainout_rdy_o    = flags.trainout_rdy;
    surf_live_o       = flags.live;
    surf_misaligned_o = flags.misaligned;
    state_o           = state_q;
    loss_count_o      = loss_cnt_q;
    live_change_o     = live_change_q;
  end

endmodule
`default_nettype wire

// File: rtl/surf_link_monitor.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | surf_link_monitor : per-SURF link boot/train/live tracking            |
// | Revision          : 1.0                                               |
// +-----------------------------------------------------------------------+
module surf_link_monitor
  import surf_link_pkg::*;
#(
  parameter int                    NUM_SURF       = 7,
  parameter int                    COUT_WIDTH     = 4,
  parameter int                    DOUT_WIDTH     = 8,
  parameter logic [DOUT_WIDTH-1:0] DOUT_TRAIN     = DOUT_WIDTH'(8'h6A),
  parameter int                    LOSS_CYCLES    = 16,
  parameter int                    LOSS_CNT_WIDTH = 8
) (
  input  logic                               sys_clk_i,
  input  logic                               sys_rst_i,
  input  logic [NUM_SURF-1:0]                enable_i,
  input  logic [NUM_SURF*COUT_WIDTH-1:0]     cout_i,
  input  logic [NUM_SURF*DOUT_WIDTH-1:0]     dout_i,
  input  logic [NUM_SURF-1:0]                train_complete_i,
  input  logic [NUM_SURF-1:0]                misalign_clr_i,
  output logic [NUM_SURF-1:0]                trainin_req_o,
  output logic [NUM_SURF-1:0]                trainout_rdy_o,
  output logic [NUM_SURF-1:0]                surf_live_o,
  output logic [NUM_SURF-1:0]                surf_misaligned_o,
  output logic [NUM_SURF*3-1:0]              state_o,
  output logic [NUM_SURF*LOSS_CNT_WIDTH-1:0] loss_count_o,
  output logic [NUM_SURF-1:0]                live_change_o
);

  for (genvar i = 0; i < NUM_SURF; i++) begin : g_chan
    surf_link_chan #(
      .COUT_WIDTH     (COUT_WIDTH),
      .DOUT_WIDTH     (DOUT_WIDTH),
      .DOUT_TRAIN     (DOUT_TRAIN),
      .LOSS_CYCLES    (LOSS_CYCLES),
      .LOSS_CNT_WIDTH (LOSS_CNT_WIDTH)
    ) u_chan (
      .sys_clk_i         (sys_clk_i),
      .sys_rst_i         (sys_rst_i),
      .enable_i          (enable_i[i]),
      .cout_i            (cout_i[COUT_WIDTH*i +: COUT_WIDTH]),
      .dout_i            (dout_i[DOUT_WIDTH*i +: DOUT_WIDTH]),
      .train_complete_i  (train_complete_i[i]),
      .misalign_clr_i    (misalign_clr_i[i]),
      .trainin_req_o     (trainin_req_o[i]),
      .trainout_rdy_o    (trainout_rdy_o[i]),
      .surf_live_o       (surf_live_o[i]),
      .surf_misaligned_o (surf_misaligned_o[i]),
      .state_o           (state_o[3*i +: 3]),
      .loss_count_o      (loss_count_o[LOSS_CNT_WIDTH*i +: LOSS_CNT_WIDTH]),
      .live_change_o     (live_change_o[i])
    );
  end

endmodule
`default_nettype wire
